// File: rtl/bcd_pkg.sv
// Shared BCD constants and elaboration-time helpers for the decade counters.
package bcd_pkg;
    localparam int BCD_W = 4;

    // Packed BCD image of a decimal integer, up to 16 decades.
    function automatic logic [63:0] to_bcd(input int unsigned value);
        logic [63:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 16; i++) begin
            r[i*BCD_W +: BCD_W] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic is_bcd(input logic [BCD_W-1:0] nib);
        return nib <= 4'd9;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// One decade: combinational next-digit logic with carry/borrow in and out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             cin,
    input  logic             up,
    output logic [BCD_W-1:0] next_digit,
    output logic             cout
);
    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit == 4'd9) begin
                    next_digit = '0;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    next_digit = 4'd9;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/bcd_counter_n.sv
// Multi-decade BCD up/down counter with validated parallel load, programmable
// wrap value and a combinational cascade enable.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 10**DIGITS - 1
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    CE,
    input  logic                    UP,
    input  logic                    LOAD,
    input  logic [BCD_W*DIGITS-1:0] D,
    output logic [BCD_W*DIGITS-1:0] Q,
    output logic                    CEO,
    output logic                    ERR
);
    localparam int W = BCD_W * DIGITS;
    localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_VAL));

    logic [DIGITS:0] carry;
    logic [W-1:0]    q_step;
    logic [W-1:0]    q_next;
    logic            d_nibbles_ok;
    logic            load_ok;
    logic            at_term;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit      (Q[i*BCD_W +: BCD_W]),
            .cin        (carry[i]),
            .up         (UP),
            .next_digit (q_step[i*BCD_W +: BCD_W]),
            .cout       (carry[i+1])
        );
    end

    always_comb begin
        d_nibbles_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(D[i*BCD_W +: BCD_W])) d_nibbles_ok = 1'b0;
        end
    end

    // With all nibbles valid, packed BCD orders the same as its decimal value.
    assign load_ok = d_nibbles_ok && (D <= MAX_BCD);

    // A borrow out of the top decade happens exactly when every decade is 0.
    assign at_term = UP ? (Q == MAX_BCD) : carry[DIGITS];
    assign q_next  = at_term ? (UP ? '0 : MAX_BCD) : q_step;
    assign CEO     = CE & ~LOAD & ~CLR & at_term;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            Q   <= '0;
            ERR <= 1'b0;
        end else if (LOAD) begin
            if (load_ok) begin
                Q   <= D;
                ERR <= 1'b0;
            end else begin
                Q   <= '0;
                ERR <= 1'b1;
            end
        end else begin
            ERR <= 1'b0;
            if (CE) Q <= q_next;
        end
    end
endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench: table vectors, directed sequences, cascade and random
// stimulus against an integer-arithmetic reference model.
module tb_bcd_counter_n;
    logic       clk = 1'b0;
    logic       clr = 1'b1, ce = 1'b0, up = 1'b1, ld = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q99, q59;
    logic       ceo99, ceo59, err99, err59;

    logic       cclr = 1'b1, cce = 1'b0;
    logic [3:0] qa, qb, cd0;
    logic [7:0] qref, cd1;
    logic       ceo_a, ceo_b, ceo_r, err_a, err_b, err_r;

    int vectors = 0;
    int errs    = 0;
    int m99 = 0, m59 = 0;
    logic e99 = 1'b0, e59 = 1'b0;
    logic ceo99_seen, ceo59_seen;

    typedef struct {
        logic       clr, ce, up, ld;
        logic [7:0] d;
        logic [7:0] q;
        logic       err;
        logic       ceo;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign cd0 = 4'h0;
    assign cd1 = 8'h00;

    bcd_counter_n #(.DIGITS(2)) dut99 (
        .CLK(clk), .CLR(clr), .CE(ce), .UP(up), .LOAD(ld), .D(d),
        .Q(q99), .CEO(ceo99), .ERR(err99));
    bcd_counter_n #(.DIGITS(2), .MAX_VAL(59)) dut59 (
        .CLK(clk), .CLR(clr), .CE(ce), .UP(up), .LOAD(ld), .D(d),
        .Q(q59), .CEO(ceo59), .ERR(err59));
    bcd_counter_n #(.DIGITS(1)) cas_a (
        .CLK(clk), .CLR(cclr), .CE(cce), .UP(1'b1), .LOAD(1'b0), .D(cd0),
        .Q(qa), .CEO(ceo_a), .ERR(err_a));
    bcd_counter_n #(.DIGITS(1)) cas_b (
        .CLK(clk), .CLR(cclr), .CE(ceo_a), .UP(1'b1), .LOAD(1'b0), .D(cd0),
        .Q(qb), .CEO(ceo_b), .ERR(err_b));
    bcd_counter_n #(.DIGITS(2)) cas_r (
        .CLK(clk), .CLR(cclr), .CE(cce), .UP(1'b1), .LOAD(1'b0), .D(cd1),
        .Q(qref), .CEO(ceo_r), .ERR(err_r));

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Decimal value of a two-digit BCD word, -1 when a nibble is not a digit.
    function automatic int bcd2int(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int model_next(input int m, input int mx, input logic c_clr,
                                      input logic c_ce, input logic c_up, input logic c_ld,
                                      input logic [7:0] c_d);
        int v;
        v = bcd2int(c_d);
        if (c_clr) return 0;
        if (c_ld) return (v >= 0 && v <= mx) ? v : 0;
        if (!c_ce) return m;
        if (c_up) return (m == mx) ? 0 : m + 1;
        return (m == 0) ? mx : m - 1;
    endfunction

    function automatic logic model_err(input int mx, input logic c_clr, input logic c_ld,
                                       input logic [7:0] c_d);
        int v;
        v = bcd2int(c_d);
        return !c_clr && c_ld && !(v >= 0 && v <= mx);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic c_clr, input logic c_ce, input logic c_up,
                         input logic c_ld, input logic [7:0] c_d);
        logic x99, x59;
        @(negedge clk);
        clr = c_clr; ce = c_ce; up = c_up; ld = c_ld; d = c_d;
        #1;
        x99 = c_ce && !c_ld && !c_clr && (c_up ? (m99 == 99) : (m99 == 0));
        x59 = c_ce && !c_ld && !c_clr && (c_up ? (m59 == 59) : (m59 == 0));
        ceo99_seen = ceo99;
        ceo59_seen = ceo59;
        chk("ceo99", {7'b0, ceo99}, {7'b0, x99});
        chk("ceo59", {7'b0, ceo59}, {7'b0, x59});
        @(posedge clk);
        m99 = model_next(m99, 99, c_clr, c_ce, c_up, c_ld, c_d);
        m59 = model_next(m59, 59, c_clr, c_ce, c_up, c_ld, c_d);
        e99 = model_err(99, c_clr, c_ld, c_d);
        e59 = model_err(59, c_clr, c_ld, c_d);
        #1;
        chk("q99", q99, int2bcd(m99));
        chk("err99", {7'b0, err99}, {7'b0, e99});
        chk("q59", q59, int2bcd(m59));
        chk("err59", {7'b0, err59}, {7'b0, e59});
    endtask

    function automatic vec_t mk(input logic c_clr, input logic c_ce, input logic c_up,
                                input logic c_ld, input logic [7:0] c_d,
                                input logic [7:0] xq, input logic xerr, input logic xceo);
        vec_t v;
        v.clr = c_clr; v.ce = c_ce; v.up = c_up; v.ld = c_ld; v.d = c_d;
        v.q = xq; v.err = xerr; v.ceo = xceo;
        return v;
    endfunction

    initial begin
        // Reset for two edges, then check reset state.
        apply(1, 0, 1, 0, 8'h00);
        apply(1, 0, 1, 0, 8'h00);
        chk("reset_q99", q99, 8'h00);
        chk("reset_err99", {7'b0, err99}, 8'h00);

        // Up count through the full 00..99 range and the wrap.
        for (int k = 1; k <= 100; k++) begin
            apply(0, 1, 1, 0, 8'h00);
            chk("up_seq", q99, int2bcd(k % 100));
            if (k == 100) chk("up_ceo_at_99", {7'b0, ceo99_seen}, 8'h01);
        end

        // Down count with borrow from 10, then wrap to 99.
        apply(0, 0, 1, 1, 8'h10);
        chk("down_load", q99, 8'h10);
        for (int k = 9; k >= 0; k--) begin
            apply(0, 1, 0, 0, 8'h00);
            chk("down_seq", q99, int2bcd(k));
        end
        apply(0, 1, 0, 0, 8'h00);
        chk("down_ceo_at_00", {7'b0, ceo99_seen}, 8'h01);
        chk("down_wrap", q99, 8'h99);

        // Table vectors aimed at the MAX_VAL=59 instance.
        tbl.push_back(mk(1, 1, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h57, 8'h57, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h00, 8'h58, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h00, 8'h59, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h59, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 8'h3A, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h75, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h42, 8'h42, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h59, 8'h59, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 8'h20, 8'h20, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h59, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h99, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 8'hF0, 8'h00, 1, 0));
        foreach (tbl[i]) begin
            apply(tbl[i].clr, tbl[i].ce, tbl[i].up, tbl[i].ld, tbl[i].d);
            chk("tbl_q59", q59, tbl[i].q);
            chk("tbl_err59", {7'b0, err59}, {7'b0, tbl[i].err});
            chk("tbl_ceo59", {7'b0, ceo59_seen}, {7'b0, tbl[i].ceo});
        end

        // Cascade of two single-decade counters against a two-decade reference.
        @(negedge clk);
        cclr = 1'b1; cce = 1'b0;
        @(negedge clk);
        cclr = 1'b0; cce = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            chk("cascade_vs_ref", {qb, qa}, qref);
            chk("cascade_count", {qb, qa}, int2bcd(k));
        end
        @(negedge clk);
        cce = 1'b0;
        chk("cascade_final", {qb, qa}, 8'h25);

        // Random stimulus against the reference model.
        for (int k = 0; k < 600; k++) begin
            logic r_clr, r_ce, r_up, r_ld;
            logic [7:0] r_d;
            r_clr = ($urandom_range(0, 31) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_ce  = ($urandom_range(0, 3) != 0);
            r_up  = ($urandom_range(0, 3) != 0) ? (k % 200 < 100) : ~(k % 200 < 100);
            if ($urandom_range(0, 1) == 1)
                r_d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                r_d = 8'($urandom);
            apply(r_clr, r_ce, r_up, r_ld, r_d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-decade synchronous BCD counter with up/down mode, parallel load, programmable wrap value and cascade output. It generalises the single-decade CE/CEO counter. One instance replaces a chain of cascaded decade counters on a shared clock, so the cascade has no clock skew. It is used for display counters, timers and event tallies in the lab designs.

## Interface

- DIGITS, 2: number of BCD decades; Q width is 4*DIGITS.
- MAX_VAL, 10**DIGITS-1: terminal decimal value. The count wraps between MAX_VAL and 0. Legal range is 1..10**DIGITS-1.

- CLK  in  1  single clock; all state changes on the rising edge.
- CLR  in  1  reset; one clock domain; reset is synchronous, active-high; name it CLR.
- CE  in  1  count enable.
- UP  in  1  direction: 1 counts up, 0 counts down.
- LOAD  in  1  parallel load strobe.
- D  in  4*DIGITS  load value, packed BCD, decade 0 in D[3:0].
- Q  out  4*DIGITS  count, packed BCD, decade 0 in Q[3:0].
- CEO  out  1  cascade/terminal-count enable output.
- ERR  out  1  one-cycle flag marking a rejected load.

## Operation

- Priority at each rising edge: CLR, then LOAD, then CE.
- CLR=1: Q is set to 0 and ERR to 0. LOAD and CE are ignored.
- LOAD=1 with D valid: Q is set to D and ERR to 0. D is valid when every nibble is 0..9 and its decimal value is at most MAX_VAL. LOAD does not depend on CE.
- LOAD=1 with D invalid: Q is set to 0 and ERR to 1.
- CE=1, UP=1: if Q==MAX_VAL, Q becomes 0. Otherwise Q increments decimally. A decade at 9 becomes 0 and carries into the next decade.
- CE=1, UP=0: if Q==0, Q becomes MAX_VAL. Otherwise Q decrements decimally. A decade at 0 becomes 9 and borrows from the next decade.
- CE=0 and no LOAD: Q holds.
- ERR is 0 on every edge that is not an invalid load, so it is a single-cycle pulse.
- CEO = CE & ~LOAD & ~CLR & (UP ? Q==MAX_VAL : Q==0). CEO is combinational. It enables the next counter stage in the same clock domain.
- Q never holds a non-BCD nibble or a value above MAX_VAL. The invariant holds from reset onward.

## Timing

- Reset values: Q=0, ERR=0. CEO=0 while CLR=1.
- Q and ERR are registered. Latency from LOAD, CE or CLR to Q/ERR is one clock edge.
- CEO has zero latency: it reflects the current Q, CE, UP, LOAD and CLR within the same cycle.
- Wrap-around occurs on the same edge as the terminal count. CEO is high during the cycle before that edge.
- A UP change with CE=1 takes effect on the next edge. No dead cycle is inserted.
- CLR asserted mid-count, or together with LOAD/CE, clears on that edge. Counting resumes on the first edge after CLR falls.
- LOAD and CE both high: the load wins and that cycle's count is lost. CEO is low in that cycle.

## Structure

- Package bcd_pkg holds:
  - the constant BCD_W=4;
  - a function converting a decimal integer to packed BCD, used to build MAX_VAL's BCD image at elaboration;
  - a function checking BCD validity of one nibble.
- Sub-module bcd_digit is one decade. It is combinational next-value logic with inputs for digit, carry/borrow-in and direction, and outputs for next digit and carry/borrow-out. It is instantiated DIGITS times in a generate loop.
- The top level holds:
  - the Q register;
  - the load validation (per-nibble check plus a packed-BCD magnitude compare against MAX_VAL);
  - the terminal-count compare and the ERR register.

## Test plan

- Reset and up count, DIGITS=2, default MAX_VAL: hold CLR for 2 edges, then set CE=1, UP=1. Expect Q=00 after reset, then 01, 02, ... 09, 10. At Q=99, CEO=1. The next edge gives Q=00.
- Down count with borrow and wrap: LOAD D=0x10, then CE=1, UP=0. Expect Q=10, 09, ... 01, 00. CEO=1 at 00. The next edge gives Q=99.
- Custom modulo, DIGITS=2, MAX_VAL=59: count up from 57. Expect 58, 59 with CEO=1, then 00. Count down from 00 and expect 59.
- Invalid loads: LOAD D=0x3A expects Q=00 and ERR=1 for exactly one cycle. With MAX_VAL=59, LOAD D=0x75 expects Q=00 and ERR=1. LOAD D=0x42 expects Q=42 and ERR=0.
- Priority and simultaneity: with Q=0x59 and MAX_VAL=59, assert CE=1, UP=1, LOAD=1, D=0x20. Expect CEO=0 and Q=20. Then assert CLR=1 with CE=1. Expect Q=00.
- Cascade: DIGITS=1 instance A drives CE of DIGITS=1 instance B from CEO. Run 25 cycles of CE=1, UP=1. Expect the combined {B,A} to be 25 and to match a DIGITS=2 reference instance every cycle.
